slf_gpio_axi: RTL

SLF_GPIO_AXI -- requirements
Module: slf_gpio_axi

---
 rtl/slf_gpio_axi_if.sv | 55 +++++
 rtl/slf_gpio_axi.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slf_gpio_axi_if.sv
// slf_gpio_axi_if: AXI4-Lite bus bundle for the
// slf_gpio_axi register block, master/slave views.
interface slf_gpio_axi_if #(
   parameter int ADDR_WIDTH = 24
);

   logic                  AXI_S_AWVALID;
   logic                  AXI_S_AWREADY;
   logic [ADDR_WIDTH-1:0] AXI_S_AWADDR;
   logic [2:0]            AXI_S_AWPROT;

   logic                  AXI_S_WVALID;
   logic                  AXI_S_WREADY;
   logic [31:0]           AXI_S_WDATA;
   logic [3:0]            AXI_S_WSTRB;

   logic                  AXI_S_BVALID;
   logic                  AXI_S_BREADY;
   logic [1:0]            AXI_S_BRESP;

   logic                  AXI_S_ARVALID;
   logic                  AXI_S_ARREADY;
   logic [ADDR_WIDTH-1:0] AXI_S_ARADDR;
   logic [2:0]            AXI_S_ARPROT;

   logic                  AXI_S_RVALID;
   logic                  AXI_S_RREADY;
   logic [31:0]           AXI_S_RDATA;
   logic [1:0]            AXI_S_RRESP;

   modport slave (
      input  AXI_S_AWVALID, AXI_S_AWADDR, AXI_S_AWPROT,
      input  AXI_S_WVALID, AXI_S_WDATA, AXI_S_WSTRB,
      input  AXI_S_BREADY,
      input  AXI_S_ARVALID, AXI_S_ARADDR, AXI_S_ARPROT,
      input  AXI_S_RREADY,
      output AXI_S_AWREADY, AXI_S_WREADY,
      output AXI_S_BVALID, AXI_S_BRESP,
      output AXI_S_ARREADY,
      output AXI_S_RVALID, AXI_S_RDATA, AXI_S_RRESP
   );

   modport master (
      output AXI_S_AWVALID, AXI_S_AWADDR, AXI_S_AWPROT,
      output AXI_S_WVALID, AXI_S_WDATA, AXI_S_WSTRB,
      output AXI_S_BREADY,
      output AXI_S_ARVALID, AXI_S_ARADDR, AXI_S_ARPROT,
      output AXI_S_RREADY,
      input  AXI_S_AWREADY, AXI_S_WREADY,
      input  AXI_S_BVALID, AXI_S_BRESP,
      input  AXI_S_ARREADY,
      input  AXI_S_RVALID, AXI_S_RDATA, AXI_S_RRESP
   );

endinterface

// File: rtl/slf_gpio_axi.sv
// slf_gpio_axi: AXI4-Lite GPIO block with LED outputs,
// synchronised inputs, edge-detect status and interrupt.
module slf_gpio_axi #(
   parameter int          ADDR_WIDTH = 24,
   parameter int          NUM_OUT    = 8,
   parameter int          NUM_IN     = 8,
   parameter logic [31:0] ID_VALUE   = 32'h534C_4701
) (
   input  logic               AXI_S_ACLK,
   input  logic               AXI_ARESETn,
   slf_gpio_axi_if.slave      axi,
   output logic               INTERRUPT,
   output logic [NUM_OUT-1:0] GPIO_OUT,
   input  logic [NUM_IN-1:0]  GPIO_IN
);

   localparam int WW = ADDR_WIDTH - 2;

   localparam logic [WW-1:0] A_OUT    = WW'(0);
   localparam logic [WW-1:0] A_IN     = WW'(1);
   localparam logic [WW-1:0] A_STATUS = WW'(2);
   localparam logic [WW-1:0] A_MASK   = WW'(3);
   localparam logic [WW-1:0] A_RISE   = WW'(4);
   localparam logic [WW-1:0] A_FALL   = WW'(5);
   localparam logic [WW-1:0] A_ID     = WW'(6);

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   // write channel state
   logic        wr_ready;
   logic        wr_pend;
   logic        bvalid;
   logic [1:0]  bresp;
   logic        wr_acc;
   logic        wr_hit;
   logic [WW-1:0] aw_word;
   logic [31:0] bmask;

   // per-register write enables
   logic wr_out;
   logic wr_st;
   logic wr_mask;
   logic wr_rise;
   logic wr_fall;

   // read channel state
   logic        rd_ready;
   logic        rvalid;
   logic [1:0]  rresp;
   logic [31:0] rdata;
   logic        rd_acc;
   logic        rd_hit;
   logic [31:0] rd_val;
   logic [WW-1:0] ar_word;

   // registers
   logic [NUM_OUT-1:0] out_q;
   logic [NUM_IN-1:0]  status;
   logic [NUM_IN-1:0]  mask;
   logic [NUM_IN-1:0]  rise_en;
   logic [NUM_IN-1:0]  fall_en;
   logic [NUM_IN-1:0]  s1;
   logic [NUM_IN-1:0]  s2;
   logic [NUM_IN-1:0]  s3;
   logic [NUM_IN-1:0]  ev;
   logic [NUM_IN-1:0]  st_clr;
   logic               irq;

   logic unused_bits;

   function automatic logic [31:0] lane_merge(
      input logic [31:0] cur,
      input logic [31:0] d,
      input logic [31:0] m
   );
      return (cur & ~m) | (d & m);
   endfunction

   assign unused_bits = ^{axi.AXI_S_AWPROT,
                          axi.AXI_S_ARPROT,
                          axi.AXI_S_AWADDR[1:0],
                          axi.AXI_S_ARADDR[1:0]};

   assign aw_word = axi.AXI_S_AWADDR[ADDR_WIDTH-1:2];
   assign ar_word = axi.AXI_S_ARADDR[ADDR_WIDTH-1:2];

   assign wr_acc = wr_ready & axi.AXI_S_AWVALID
                 & axi.AXI_S_WVALID;
   assign rd_acc = rd_ready & axi.AXI_S_ARVALID;

   assign bmask = {{8{axi.AXI_S_WSTRB[3]}},
                   {8{axi.AXI_S_WSTRB[2]}},
                   {8{axi.AXI_S_WSTRB[1]}},
                   {8{axi.AXI_S_WSTRB[0]}}};

   assign axi.AXI_S_AWREADY = wr_ready;
   assign axi.AXI_S_WREADY  = wr_ready;
   assign axi.AXI_S_BVALID  = bvalid;
   assign axi.AXI_S_BRESP   = bresp;
   assign axi.AXI_S_ARREADY = rd_ready;
   assign axi.AXI_S_RVALID  = rvalid;
   assign axi.AXI_S_RDATA   = rdata;
   assign axi.AXI_S_RRESP   = rresp;

   assign GPIO_OUT  = out_q;
   assign INTERRUPT = irq;

   // write address decode; RO offsets hit but enable nothing
   always_comb begin
      wr_hit  = 1'b1;
      wr_out  = 1'b0;
      wr_st   = 1'b0;
      wr_mask = 1'b0;
      wr_rise = 1'b0;
      wr_fall = 1'b0;
      case (aw_word)
         A_OUT:    wr_out  = wr_acc;
         A_STATUS: wr_st   = wr_acc;
         A_MASK:   wr_mask = wr_acc;
         A_RISE:   wr_rise = wr_acc;
         A_FALL:   wr_fall = wr_acc;
         A_IN,
         A_ID:     wr_hit  = 1'b1;
         default:  wr_hit  = 1'b0;
      endcase
   end

   // read address decode and zero-extended read mux
   always_comb begin
      rd_hit = 1'b1;
      rd_val = '0;
      case (ar_word)
         A_OUT:    rd_val = 32'(out_q);
         A_IN:     rd_val = 32'(s2);
         A_STATUS: rd_val = 32'(status);
         A_MASK:   rd_val = 32'(mask);
         A_RISE:   rd_val = 32'(rise_en);
         A_FALL:   rd_val = 32'(fall_en);
         A_ID:     rd_val = ID_VALUE;
         default:  rd_hit = 1'b0;
      endcase
   end

   // write handshake: ready pulse, accept, response one edge later
   always_ff @(posedge AXI_S_ACLK or negedge AXI_ARESETn) begin
      if (!AXI_ARESETn) begin
         wr_ready <= 1'b0;
         wr_pend  <= 1'b0;
         bvalid   <= 1'b0;
         bresp    <= OKAY;
      end else begin
         wr_ready <= ~wr_ready & ~wr_pend & ~bvalid
                   & axi.AXI_S_AWVALID & axi.AXI_S_WVALID;
         wr_pend  <= wr_acc;
         if (wr_acc) begin
            bresp <= wr_hit ? OKAY : SLVERR;
         end
         if (wr_pend) begin
            bvalid <= 1'b1;
         end else if (bvalid && axi.AXI_S_BREADY) begin
            bvalid <= 1'b0;
         end
      end
   end

   // read handshake: ready pulse, data captured on the accept edge
   always_ff @(posedge AXI_S_ACLK or negedge AXI_ARESETn) begin
      if (!AXI_ARESETn) begin
         rd_ready <= 1'b0;
         rvalid   <= 1'b0;
         rdata    <= '0;
         rresp    <= OKAY;
      end else begin
         rd_ready <= ~rd_ready & ~rvalid & axi.AXI_S_ARVALID;
         if (rd_acc) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= rd_hit ? OKAY : SLVERR;
         end else if (rvalid && axi.AXI_S_RREADY) begin
            rvalid <= 1'b0;
         end
      end
   end

   // input synchroniser plus history flop for edge detect
   always_ff @(posedge AXI_S_ACLK or negedge AXI_ARESETn) begin
      if (!AXI_ARESETn) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= GPIO_IN;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // RW registers with per-lane strobes, truncated to width
   always_ff @(posedge AXI_S_ACLK or negedge AXI_ARESETn) begin
      if (!AXI_ARESETn) begin
         out_q   <= '0;
         mask    <= '0;
         rise_en <= '0;
         fall_en <= '0;
      end else begin
         if (wr_out) begin
            out_q <= NUM_OUT'(lane_merge(32'(out_q),
                                         axi.AXI_S_WDATA, bmask));
         end
         if (wr_mask) begin
            mask <= NUM_IN'(lane_merge(32'(mask),
                                       axi.AXI_S_WDATA, bmask));
         end
         if (wr_rise) begin
            rise_en <= NUM_IN'(lane_merge(32'(rise_en),
                                          axi.AXI_S_WDATA, bmask));
         end
         if (wr_fall) begin
            fall_en <= NUM_IN'(lane_merge(32'(fall_en),
                                          axi.AXI_S_WDATA, bmask));
         end
      end
   end

   assign ev = (s2 & ~s3 & rise_en) | (~s2 & s3 & fall_en);

   assign st_clr = wr_st ? NUM_IN'(axi.AXI_S_WDATA & bmask)
                         : '0;

   // sticky status: W1C clear, a same-edge set event wins
   always_ff @(posedge AXI_S_ACLK or negedge AXI_ARESETn) begin
      if (!AXI_ARESETn) begin
         status <= '0;
      end else begin
         status <= (status & ~st_clr) | ev;
      end
   end

   // interrupt follows current status and mask one edge later
   always_ff @(posedge AXI_S_ACLK or negedge AXI_ARESETn) begin
      if (!AXI_ARESETn) begin
         irq <= 1'b0;
      end else begin
         irq <= |(status & mask);
      end
   end

endmodule
